// File: rtl/bp_pkg.sv
// Shared BTB geometry, counter encodings and entry layout for the branch predictor.
package bp_pkg;

  localparam int unsigned BTB_IDX_W = 6;
  localparam int unsigned BTB_TAG_W = 24;

  localparam logic [1:0] CNT_RST   = 2'b01;
  localparam logic [1:0] CNT_ALLOC = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           cnt;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating direction counter, one per BTB entry.
module bp_sat_cnt
  import bp_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q, cnt_d;

  // Load wins over training so allocation always starts from a known value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != 2'b11)) begin
      cnt_d = cnt_q + 2'd1;
    end else if (dec && (cnt_q != 2'b00)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, flop-based BTB with 2-bit counters; 1-cycle registered prediction
// and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int unsigned BTB_IDX_W = bp_pkg::BTB_IDX_W,
  parameter int unsigned BTB_TAG_W = bp_pkg::BTB_TAG_W
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_stall,
  output logic        pred_valid,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_tpc,
  input  logic        upd_taken,
  input  logic        upd_mispred,
  output logic [31:0] stat_br_cnt,
  output logic [31:0] stat_mis_cnt
);

  import bp_pkg::CNT_ALLOC;
  import bp_pkg::btb_entry_t;

  localparam int unsigned NumEntries = 1 << BTB_IDX_W;

  logic [NumEntries-1:0] valid_q;
  logic [BTB_TAG_W-1:0]  tag_q    [NumEntries];
  logic [31:0]           target_q [NumEntries];
  logic [1:0]            cnt      [NumEntries];

  logic [BTB_IDX_W-1:0] fetch_idx, upd_idx;
  logic [BTB_TAG_W-1:0] fetch_tag, upd_tag;
  btb_entry_t           rd_entry, up_entry;
  logic                 lookup_hit, lookup_taken;
  logic [31:0]          lookup_npc;
  logic                 upd_hit, upd_train, upd_alloc;

  assign fetch_idx = fetch_pc[BTB_IDX_W+1:2];
  assign fetch_tag = fetch_pc[31:32-BTB_TAG_W];
  assign upd_idx   = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag   = upd_pc[31:32-BTB_TAG_W];

  // Lookups read the current flop contents, so a same-cycle update is not visible.
  always_comb begin
    rd_entry.valid  = valid_q[fetch_idx];
    rd_entry.tag    = tag_q[fetch_idx];
    rd_entry.target = target_q[fetch_idx];
    rd_entry.cnt    = cnt[fetch_idx];
    up_entry.valid  = valid_q[upd_idx];
    up_entry.tag    = tag_q[upd_idx];
    up_entry.target = target_q[upd_idx];
    up_entry.cnt    = cnt[upd_idx];
  end

  assign lookup_hit   = rd_entry.valid && (rd_entry.tag == fetch_tag);
  assign lookup_taken = lookup_hit && rd_entry.cnt[1];
  assign lookup_npc   = lookup_taken ? rd_entry.target : fetch_pc + 32'd4;

  assign upd_hit   = up_entry.valid && (up_entry.tag == upd_tag);
  assign upd_train = upd_valid && upd_hit;
  assign upd_alloc = upd_valid && !upd_hit && upd_taken;

  for (genvar i = 0; i < NumEntries; i++) begin : g_cnt
    logic sel;
    assign sel = (upd_idx == BTB_IDX_W'(i));

    bp_sat_cnt u_sat_cnt (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .inc      (sel && upd_train && upd_taken),
      .dec      (sel && upd_train && !upd_taken),
      .load     (sel && upd_alloc),
      .load_val (CNT_ALLOC),
      .cnt      (cnt[i])
    );
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_q <= '0;
    end else if (upd_alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag/target carry no reset; valid bits gate their use.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      if (upd_alloc) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_tpc;
      end else if (upd_train && upd_taken) begin
        target_q[upd_idx] <= upd_tpc;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pred_valid <= 1'b0;
      pred_pc    <= '0;
      pred_taken <= 1'b0;
      pred_npc   <= '0;
    end else if (!fetch_stall) begin
      pred_valid <= fetch_valid;
      if (fetch_valid) begin
        pred_pc    <= fetch_pc;
        pred_taken <= lookup_taken;
        pred_npc   <= lookup_npc;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_br_cnt  <= '0;
      stat_mis_cnt <= '0;
    end else if (upd_valid) begin
      if (stat_br_cnt != 32'hFFFF_FFFF) begin
        stat_br_cnt <= stat_br_cnt + 32'd1;
      end
      if (upd_mispred && (stat_mis_cnt != 32'hFFFF_FFFF)) begin
        stat_mis_cnt <= stat_mis_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
module tb_branch_predictor;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        fetch_valid, fetch_stall;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_pc, pred_npc;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [31:0] upd_pc, upd_tpc;
  logic [31:0] stat_br_cnt, stat_mis_cnt;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mis = 0;

  always #5 aclk = ~aclk;

  branch_predictor dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_stall  (fetch_stall),
    .pred_valid   (pred_valid),
    .pred_pc      (pred_pc),
    .pred_taken   (pred_taken),
    .pred_npc     (pred_npc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_tpc      (upd_tpc),
    .upd_taken    (upd_taken),
    .upd_mispred  (upd_mispred),
    .stat_br_cnt  (stat_br_cnt),
    .stat_mis_cnt (stat_mis_cnt)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        st;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utpc;
    logic        ut;
    logic        um;
    logic        ev;
    logic        et;
    logic [31:0] epc;
    logic [31:0] enpc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [31:0] fpc, input logic st,
                     input logic uv, input logic [31:0] upc, input logic [31:0] utpc,
                     input logic ut, input logic um,
                     input logic ev, input logic et, input logic [31:0] epc,
                     input logic [31:0] enpc);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.st = st; v.uv = uv; v.upc = upc; v.utpc = utpc;
    v.ut = ut; v.um = um; v.ev = ev; v.et = et; v.epc = epc; v.enpc = enpc;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    fetch_valid = v.fv; fetch_pc = v.fpc; fetch_stall = v.st;
    upd_valid = v.uv; upd_pc = v.upc; upd_tpc = v.utpc;
    upd_taken = v.ut; upd_mispred = v.um;
  endtask

  task automatic idle();
    fetch_valid = 0; fetch_pc = 0; fetch_stall = 0;
    upd_valid = 0; upd_pc = 0; upd_tpc = 0; upd_taken = 0; upd_mispred = 0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic upd_only(input logic [31:0] pc, input logic [31:0] tpc, input logic t,
                          input logic m);
    idle();
    upd_valid = 1; upd_pc = pc; upd_tpc = tpc; upd_taken = t; upd_mispred = m;
    tick();
  endtask

  initial begin
    // Reset with live fetch/update traffic; reset must win.
    idle();
    aresetn = 0;
    fetch_valid = 1; fetch_pc = 32'h1C00_0000;
    upd_valid = 1; upd_pc = 32'h1C00_0000; upd_tpc = 32'h1C00_0800; upd_taken = 1;
    upd_mispred = 1;
    tick();
    tick();
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_pc", pred_pc, 32'd0);
    chk("rst_pred_npc", pred_npc, 32'd0);
    chk("rst_stat_br", stat_br_cnt, 32'd0);
    chk("rst_stat_mis", stat_mis_cnt, 32'd0);
    idle();
    aresetn = 1;

    //   fv fpc            st uv upc            utpc           ut um  ev et epc            enpc
    add(1, 32'h1C00_0000, 0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h1C00_0000, 32'h1C00_0004);
    add(0, 32'h0,         0, 1, 32'h1C00_0010, 32'h1C00_0100, 1, 1,  0, 0, 32'h1C00_0000, 32'h1C00_0004);
    add(1, 32'h1C00_0010, 0, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0010, 32'h1C00_0100);
    add(0, 32'h0,         0, 1, 32'h1C00_0010, 32'h0,         0, 1,  0, 1, 32'h1C00_0010, 32'h1C00_0100);
    add(0, 32'h0,         0, 1, 32'h1C00_0010, 32'h0,         0, 0,  0, 1, 32'h1C00_0010, 32'h1C00_0100);
    add(0, 32'h0,         0, 1, 32'h1C00_0010, 32'h0,         0, 0,  0, 1, 32'h1C00_0010, 32'h1C00_0100);
    add(1, 32'h1C00_0010, 0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h1C00_0010, 32'h1C00_0014);
    add(0, 32'h0,         0, 1, 32'h1C00_0010, 32'h1C00_0180, 1, 0,  0, 0, 32'h1C00_0010, 32'h1C00_0014);
    add(0, 32'h0,         0, 1, 32'h1C00_0110, 32'h1C00_0200, 1, 1,  0, 0, 32'h1C00_0010, 32'h1C00_0014);
    add(1, 32'h1C00_0010, 0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h1C00_0010, 32'h1C00_0014);
    add(1, 32'h1C00_0110, 0, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0110, 32'h1C00_0200);
    add(0, 32'h0,         0, 1, 32'h1C00_0110, 32'h1C00_0200, 1, 0,  0, 1, 32'h1C00_0110, 32'h1C00_0200);
    add(0, 32'h0,         0, 1, 32'h1C00_0110, 32'h1C00_0200, 1, 0,  0, 1, 32'h1C00_0110, 32'h1C00_0200);
    add(0, 32'h0,         0, 1, 32'h1C00_0110, 32'h1C00_0200, 1, 0,  0, 1, 32'h1C00_0110, 32'h1C00_0200);
    add(1, 32'h1C00_0110, 0, 1, 32'h1C00_0110, 32'h0,         0, 1,  1, 1, 32'h1C00_0110, 32'h1C00_0200);
    add(1, 32'h1C00_0110, 0, 1, 32'h1C00_0110, 32'h0,         0, 0,  1, 1, 32'h1C00_0110, 32'h1C00_0200);
    add(1, 32'h1C00_0110, 0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h1C00_0110, 32'h1C00_0114);
    add(0, 32'h0,         0, 1, 32'h1C00_0030, 32'h1C00_0400, 0, 1,  0, 0, 32'h1C00_0110, 32'h1C00_0114);
    add(1, 32'h1C00_0030, 0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h1C00_0030, 32'h1C00_0034);
    add(1, 32'h1C00_0020, 0, 1, 32'h1C00_0020, 32'h1C00_0300, 1, 0,  1, 0, 32'h1C00_0020, 32'h1C00_0024);
    add(1, 32'h1C00_0020, 0, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0020, 32'h1C00_0300);
    add(1, 32'h1C00_0000, 1, 1, 32'h1C00_0000, 32'h1C00_0500, 1, 0,  1, 1, 32'h1C00_0020, 32'h1C00_0300);
    add(0, 32'h1C00_0110, 1, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0020, 32'h1C00_0300);
    add(1, 32'h1C00_0030, 1, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0020, 32'h1C00_0300);
    add(1, 32'h1C00_0000, 0, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0000, 32'h1C00_0500);
    add(0, 32'h0,         0, 1, 32'h1C00_0020, 32'h1C00_0600, 1, 0,  0, 1, 32'h1C00_0000, 32'h1C00_0500);
    add(1, 32'h1C00_0020, 0, 0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1C00_0020, 32'h1C00_0600);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      if (vecs[i].uv) begin
        exp_br++;
        if (vecs[i].um) exp_mis++;
      end
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, pred_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].et});
      chk($sformatf("v%0d_pc", i), pred_pc, vecs[i].epc);
      chk($sformatf("v%0d_npc", i), pred_npc, vecs[i].enpc);
    end
    idle();
    chk("tbl_stat_br", stat_br_cnt, exp_br);
    chk("tbl_stat_mis", stat_mis_cnt, exp_mis);

    // Second reset must invalidate every entry and clear the statistics.
    aresetn = 0;
    tick();
    aresetn = 1;
    fetch_valid = 1; fetch_pc = 32'h1C00_0020;
    tick();
    chk("rst2_valid", {31'd0, pred_valid}, 32'd1);
    chk("rst2_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst2_npc", pred_npc, 32'h1C00_0024);
    chk("rst2_stat_br", stat_br_cnt, 32'd0);

    upd_only(32'h1C00_0040, 32'h1C00_0700, 1, 1);
    upd_only(32'h1C00_0040, 32'h1C00_0700, 1, 0);
    upd_only(32'h1C00_0044, 32'h0,         0, 1);
    upd_only(32'h1C00_0040, 32'h1C00_0700, 0, 0);
    upd_only(32'h1C00_0048, 32'h0,         0, 0);
    idle();
    tick();
    chk("stat_br_5", stat_br_cnt, 32'd5);
    chk("stat_mis_2", stat_mis_cnt, 32'd2);

    // Counter 10 -> 11 -> 10 leaves the entry predicting taken.
    fetch_valid = 1; fetch_pc = 32'h1C00_0040;
    tick();
    chk("post_taken", {31'd0, pred_taken}, 32'd1);
    chk("post_npc", pred_npc, 32'h1C00_0700);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_IDX_W, default 6; index width, giving 64 direct-mapped entries.
REQ-002 SHALL have parameter BTB_TAG_W, default 24; tag width, taken from pc[31:8].
REQ-003 aclk  in  1  clock; all state updates on posedge aclk.
REQ-004 aresetn  in  1  reset; synchronous, active-low.
REQ-005 fetch_valid  in  1  fetch_pc is a valid lookup request this cycle.
REQ-006 fetch_pc  in  32  word-aligned PC of the fetched instruction.
REQ-007 fetch_stall  in  1  hold all prediction output registers.
REQ-008 pred_valid  out  1  registered; the prediction outputs are valid.
REQ-009 pred_pc  out  32  registered; fetch_pc that produced this prediction.
REQ-010 pred_taken  out  1  registered; predicted taken (drives predict_to_branch at EX1).
REQ-011 pred_npc  out  32  registered; predicted next PC (drives pc0_predict at EX1).
REQ-012 upd_valid  in  1  resolved branch report from EX1, single cycle.
REQ-013 upd_pc  in  32  resolved branch PC (fact_pc).
REQ-014 upd_tpc  in  32  resolved target (fact_tpc).
REQ-015 upd_taken  in  1  actual direction (fact_taken).
REQ-016 upd_mispred  in  1  predict_dir_fail OR predict_addr_fail.
REQ-017 stat_br_cnt  out  32  count of upd_valid events.
REQ-018 stat_mis_cnt  out  32  count of upd_valid && upd_mispred events.

Function
REQ-019 Each BTB entry SHALL hold valid, tag[BTB_TAG_W], target[32] and a 2-bit saturating counter; index = pc[BTB_IDX_W+1:2].
REQ-020 Lookup: hit = entry.valid && entry.tag == fetch_pc[31:8]; taken = hit && cnt[1]; npc = taken ? target : fetch_pc+4.
REQ-021 Latency SHALL be 1 cycle: when fetch_valid && !fetch_stall, pred_* load on the next edge; pred_valid = fetch_valid.
REQ-022 When fetch_stall = 1, all pred_* registers SHALL hold their values regardless of fetch_valid.
REQ-023 Update on hit (tag match): the counter SHALL increment when upd_taken and decrement when not taken, saturating at 3 and 0; on taken, target SHALL be rewritten with upd_tpc.
REQ-024 Update on miss with upd_taken: the entry SHALL be allocated (valid=1, tag, target=upd_tpc, cnt=2'b10), replacing any occupant.
REQ-025 Update on miss with !upd_taken: the BTB SHALL be unchanged.
REQ-026 Lookup and update to the same index in the same cycle: the lookup SHALL see pre-update contents (read-before-write).
REQ-027 Counters SHALL increment on their events and saturate at 32'hFFFF_FFFF, without wrapping.
REQ-028 upd_mispred SHALL affect only stat_mis_cnt; table training SHALL depend only on upd_taken and upd_tpc.

Reset
REQ-029 While aresetn = 0: all entry valid bits = 0, all counters = 2'b01, pred_valid = 0, pred_taken = 0, pred_pc = 0, pred_npc = 0, stat_* = 0.
REQ-030 Reset SHALL override a simultaneous upd_valid or fetch_valid; tag and target fields need not be reset.
REQ-031 After reset releases, the first lookup SHALL miss and predict fetch_pc+4.

Structure
REQ-032 BTB_IDX_W, BTB_TAG_W, the counter reset value 2'b01, the allocate value 2'b10 and the entry struct SHALL live in shared package bp_pkg.
REQ-033 The 2-bit saturating counter SHALL be a sub-module bp_sat_cnt (inputs inc, dec, load, load_val), instantiated per entry.
REQ-034 The table SHALL be flop-based, because reset must clear the valid bits in one cycle.

Verification
REQ-035 Reset, then fetch 0x1C000000 -> next cycle pred_valid=1, pred_taken=0, pred_npc=0x1C000004.
REQ-036 upd(pc=0x1C000010, tpc=0x1C000100, taken=1), then fetch 0x1C000010 -> pred_taken=1, pred_npc=0x1C000100.
REQ-037 Starting from the state after REQ-036, three not-taken updates at 0x1C000010 -> counter 10->01->00->00; fetch -> pred_taken=0, npc=0x1C000014.
REQ-038 Alias: allocate 0x1C000010, then taken update at 0x1C000110 (same index) -> fetch 0x1C000010 misses (npc=+4); fetch 0x1C000110 hits.
REQ-039 Same-cycle fetch and update to 0x1C000020 on an empty entry -> that cycle's prediction is a miss; a refetch next cycle predicts taken.
REQ-040 fetch_stall=1 for 3 cycles while fetch_pc changes -> pred_* hold their values; 5 updates with 2 mispred -> stat_br_cnt=5, stat_mis_cnt=2.
